puf_readout_ctrl: RTL and testbench

- Sequencer wrapped around the multi-bit PUF array. Drives the array's START and addr inputs and consumes its registered OUT_BITS-wide read data.
- Runs NUM_EVALS excite/resolve/sweep evaluations and accumulates a per-bit vote count for every PUF bit.
- Streams one majority-voted word per address, plus a per-bit instability mask, over a valid/ready interface to the key/ID consumer.

---
 rtl/puf_readout_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_puf_readout_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_readout_ctrl.sv
// puf_readout_ctrl: sequences repeated excite/resolve/sweep evaluations of a
// multi-bit PUF array, keeps a per-bit vote count for every word, and streams
// one majority-voted word plus an instability mask per address.
//
// Stream handshake: out_valid is high for the whole STREAM state. While it is
// high, out_addr/out_data/out_unstable do not change until the cycle after a
// beat with out_valid & out_ready. That handshake advances to the next word,
// with no bubble in between.
module puf_readout_ctrl #(
   parameter int ADDR_BITS     = 4,
   parameter int OUT_BITS      = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int NUM_EVALS     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   output logic                 busy,
   output logic                 done,
   output logic                 puf_start,
   output logic [ADDR_BITS-1:0] puf_addr,
   input  logic [OUT_BITS-1:0]  puf_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_BITS-1:0] out_addr,
   output logic [OUT_BITS-1:0]  out_data,
   output logic [OUT_BITS-1:0]  out_unstable
);

   localparam int NWORDS = 1 << ADDR_BITS;
   localparam int CW     = $clog2(NUM_EVALS + 1);

   localparam logic [15:0]          SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [ADDR_BITS:0]   SWEEP_LAST  = (ADDR_BITS + 1)'(NWORDS);
   localparam logic [ADDR_BITS:0]   SWEEP_ONE   = (ADDR_BITS + 1)'(1);
   localparam logic [ADDR_BITS-1:0] BEAT_LAST   = ADDR_BITS'(NWORDS - 1);
   localparam logic [ADDR_BITS-1:0] BEAT_ONE    = ADDR_BITS'(1);
   localparam logic [CW-1:0]        EVAL_LAST   = CW'(NUM_EVALS - 1);
   localparam logic [CW-1:0]        EVAL_ONE    = CW'(1);
   localparam logic [CW-1:0]        VOTE_HALF   = CW'(NUM_EVALS / 2);
   localparam logic [CW-1:0]        VOTE_FULL   = CW'(NUM_EVALS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXCITE,
      S_RESOLVE,
      S_SWEEP,
      S_STREAM,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [15:0]          phase_cnt;   // cycles spent in EXCITE or RESOLVE
   logic [ADDR_BITS:0]   sweep_cnt;   // SWEEP cycle index, 0..NWORDS
   logic [CW-1:0]        eval_cnt;    // completed evaluations
   logic [ADDR_BITS-1:0] beat;        // current stream word
   logic                 cap_valid;   // puf_data holds the word at cap_addr
   logic [ADDR_BITS-1:0] cap_addr;
   logic [CW-1:0]        votes [NWORDS][OUT_BITS];

   logic                 phase_end;
   logic                 sweep_end;
   logic [OUT_BITS-1:0]  maj_word;
   logic [OUT_BITS-1:0]  unst_word;

   assign phase_end = (phase_cnt == SETTLE_LAST);
   assign sweep_end = (sweep_cnt == SWEEP_LAST);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and all control outputs, decoded from the current state.
   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      done         = 1'b0;
      puf_start    = 1'b0;
      puf_addr     = '0;
      out_valid    = 1'b0;
      out_addr     = '0;
      out_data     = '0;
      out_unstable = '0;
      case (state)
         S_IDLE: begin
            if (go) state_nxt = S_EXCITE;
         end
         S_EXCITE: begin
            busy      = 1'b1;
            puf_start = 1'b1;
            if (phase_end) state_nxt = S_RESOLVE;
         end
         S_RESOLVE: begin
            busy = 1'b1;
            if (phase_end) state_nxt = S_SWEEP;
         end
         S_SWEEP: begin
            busy = 1'b1;
            // The final cycle only captures the last word, address parks at 0.
            if (!sweep_end) puf_addr = sweep_cnt[ADDR_BITS-1:0];
            if (sweep_end) state_nxt = (eval_cnt == EVAL_LAST) ? S_STREAM : S_EXCITE;
         end
         S_STREAM: begin
            busy         = 1'b1;
            out_valid    = 1'b1;
            out_addr     = beat;
            out_data     = maj_word;
            out_unstable = unst_word;
            if (out_ready && beat == BEAT_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Majority and instability decode of the word currently being streamed.
   always_comb begin
      maj_word  = '0;
      unst_word = '0;
      for (int b = 0; b < OUT_BITS; b++) begin
         maj_word[b]  = (votes[beat][b] > VOTE_HALF);
         unst_word[b] = (votes[beat][b] != '0) && (votes[beat][b] != VOTE_FULL);
      end
   end

   // Phase, sweep, evaluation and beat counters plus the capture pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_cnt <= '0;
         sweep_cnt <= '0;
         eval_cnt  <= '0;
         beat      <= '0;
         cap_valid <= 1'b0;
         cap_addr  <= '0;
      end else begin
         if ((state == S_EXCITE || state == S_RESOLVE) && !phase_end)
            phase_cnt <= phase_cnt + 16'd1;
         else
            phase_cnt <= '0;

         if (state == S_SWEEP && !sweep_end)
            sweep_cnt <= sweep_cnt + SWEEP_ONE;
         else
            sweep_cnt <= '0;

         if (state == S_IDLE && go)
            eval_cnt <= '0;
         else if (state == S_SWEEP && sweep_end)
            eval_cnt <= eval_cnt + EVAL_ONE;

         if (state != S_STREAM)
            beat <= '0;
         else if (out_ready)
            beat <= beat + BEAT_ONE;

         // The array answers one cycle after the address, so remember which
         // word is in flight rather than trusting the live puf_addr.
         cap_valid <= (state == S_SWEEP) && !sweep_end;
         cap_addr  <= sweep_cnt[ADDR_BITS-1:0];
      end
   end

   // Vote counters: cleared when a run is accepted, bumped on each captured 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NWORDS; w++)
            for (int b = 0; b < OUT_BITS; b++)
               votes[w][b] <= '0;
      end else if (state == S_IDLE && go) begin
         for (int w = 0; w < NWORDS; w++)
            for (int b = 0; b < OUT_BITS; b++)
               votes[w][b] <= '0;
      end else if (cap_valid) begin
         for (int b = 0; b < OUT_BITS; b++)
            votes[cap_addr][b] <= votes[cap_addr][b] + CW'(puf_data[b]);
      end
   end

endmodule

// File: tb/tb_puf_readout_ctrl.sv
// Bench for puf_readout_ctrl: a default-parameter instance driven through a
// table of run scenarios, plus a minimal-size corner instance.
module tb_puf_readout_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       go;
   logic       busy, done, puf_start;
   logic [3:0] puf_addr;
   logic [7:0] puf_data;
   logic       out_valid, out_ready;
   logic [3:0] out_addr;
   logic [7:0] out_data, out_unstable;

   logic       c_go;
   logic       c_busy, c_done, c_puf_start;
   logic [0:0] c_puf_addr;
   logic [1:0] c_puf_data;
   logic       c_out_valid;
   logic       c_out_ready;
   logic [0:0] c_out_addr;
   logic [1:0] c_out_data, c_out_unstable;

   puf_readout_ctrl dut (
      .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done),
      .puf_start(puf_start), .puf_addr(puf_addr), .puf_data(puf_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_unstable(out_unstable)
   );

   puf_readout_ctrl #(
      .ADDR_BITS(1), .OUT_BITS(2), .SETTLE_CYCLES(1), .NUM_EVALS(1)
   ) dut_c (
      .clk(clk), .reset(reset), .go(c_go), .busy(c_busy), .done(c_done),
      .puf_start(c_puf_start), .puf_addr(c_puf_addr), .puf_data(c_puf_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_addr(c_out_addr),
      .out_data(c_out_data), .out_unstable(c_out_unstable)
   );

   // ---------------- array models ----------------
   // mode 0: word = {4'hA, addr}; mode 1: only bit 0 of word 3 toggles per eval.
   int         mode_r = 0;
   int         rises  = 0;
   int         base   = 0;
   logic       start_prev = 1'b0;
   logic [4:0] pat = 5'b01011;       // evals 0..4 read 1,1,0,1,0
   logic [7:0] nd;
   logic [1:0] c_nd;

   // Count EXCITE entries and look up the next read word away from the edge.
   always @(negedge clk) begin
      int e;
      start_prev <= puf_start;
      if (puf_start && !start_prev) rises <= rises + 1;
      e = rises - base - 1;
      if (e < 0) e = 0;
      if (e > 4) e = 4;
      if (mode_r == 0) nd <= {4'hA, puf_addr};
      else             nd <= (puf_addr == 4'd3 && pat[e]) ? 8'h01 : 8'h00;
      c_nd <= {c_puf_addr[0], ~c_puf_addr[0]};
   end

   // Registered read data, one cycle behind the address.
   always @(posedge clk) begin
      puf_data   <= nd;
      c_puf_data <= c_nd;
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] unst;
   } beat_t;

   typedef struct {
      int mode;   // array model
      int bp;     // 1: out_ready pattern 0,0,1
      int inj;    // 1: extra go pulses in SWEEP, STREAM and DONE
   } scen_t;

   beat_t exp_tab[16];
   scen_t scen[5];

   task automatic fill_tab(input int mode);
      for (int k = 0; k < 16; k++) begin
         exp_tab[k].addr = 4'(k);
         if (mode == 0) begin
            exp_tab[k].data = {4'hA, 4'(k)};
            exp_tab[k].unst = 8'h00;
         end else begin
            exp_tab[k].data = (k == 3) ? 8'h01 : 8'h00;
            exp_tab[k].unst = (k == 3) ? 8'h01 : 8'h00;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_one(input int mode, input int bp, input int inj);
      int n;
      int k;
      int cyc;
      int stalled;
      logic [3:0] h_addr;
      logic [7:0] h_data, h_unst;
      fill_tab(mode);
      mode_r    = mode;
      base      = rises;
      out_ready = 1'b1;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      chk("busy_after_go", {31'd0, busy}, 32'd1);
      n = 0;
      while (!out_valid && n < 400) begin
         go = (inj != 0 && n == 40) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         n++;
      end
      go = 1'b0;
      chk("first_valid_latency", n, 245);
      k = 0; cyc = 0; stalled = 0;
      h_addr = '0; h_data = '0; h_unst = '0;
      while (k < 16 && cyc < 200) begin
         out_ready = (bp != 0) ? (cyc % 3 == 2) : 1'b1;
         go = (inj != 0 && cyc == 0) ? 1'b1 : 1'b0;
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
         if (stalled != 0) begin
            chk("hold_addr", {28'd0, out_addr}, {28'd0, h_addr});
            chk("hold_data", {24'd0, out_data}, {24'd0, h_data});
            chk("hold_unst", {24'd0, out_unstable}, {24'd0, h_unst});
         end
         if (out_ready) begin
            chk("beat_addr", {28'd0, out_addr}, {28'd0, exp_tab[k].addr});
            chk("beat_data", {24'd0, out_data}, {24'd0, exp_tab[k].data});
            chk("beat_unst", {24'd0, out_unstable}, {24'd0, exp_tab[k].unst});
            k++;
            stalled = 0;
         end else begin
            stalled = 1;
            h_addr = out_addr; h_data = out_data; h_unst = out_unstable;
         end
         @(posedge clk); #1;
         cyc++;
      end
      go = 1'b0;
      out_ready = 1'b1;
      chk("beats_handshaken", k, 16);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("valid_in_done", {31'd0, out_valid}, 32'd0);
      go = (inj != 0) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      go = 1'b0;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("go_in_done_ignored", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_start"}, {31'd0, puf_start}, 32'd0);
      chk({tag, "_puf_addr"}, {28'd0, puf_addr}, 32'd0);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_addr"}, {28'd0, out_addr}, 32'd0);
      chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
      chk({tag, "_out_unst"}, {24'd0, out_unstable}, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int starts;
      reset = 1'b1; go = 1'b0; out_ready = 1'b1;
      c_go = 1'b0; c_out_ready = 1'b1;

      scen[0] = '{mode: 0, bp: 0, inj: 0};   // defaults
      scen[1] = '{mode: 1, bp: 0, inj: 0};   // noisy bit
      scen[2] = '{mode: 0, bp: 1, inj: 0};   // backpressure
      scen[3] = '{mode: 0, bp: 0, inj: 1};   // stray go pulses
      scen[4] = '{mode: 0, bp: 0, inj: 0};   // fresh run, same result

      repeat (3) @(posedge clk);
      #1;
      chk_quiet("in_reset");
      reset = 1'b0;
      @(posedge clk); #1;
      chk_quiet("after_reset");

      for (int s = 0; s < 5; s++)
         run_one(scen[s].mode, scen[s].bp, scen[s].inj);

      // Reset in the third EXCITE phase (edges 98..113 after acceptance).
      mode_r = 1;
      base   = rises;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("third_excite_start", {31'd0, puf_start}, 32'd1);
      reset = 1'b1;
      #1;
      chk_quiet("async_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", {31'd0, busy}, 32'd0);
      run_one(0, 0, 0);

      // Minimal corner instance: one eval, one-cycle phases, two words.
      c_go = 1'b1;
      @(posedge clk); #1;
      c_go = 1'b0;
      n = 0; starts = 0;
      while (!c_out_valid && n < 50) begin
         if (c_puf_start) starts++;
         @(posedge clk); #1;
         n++;
      end
      chk("c_latency", n, 5);
      chk("c_start_cycles", starts, 1);
      for (int k = 0; k < 2; k++) begin
         chk("c_valid", {31'd0, c_out_valid}, 32'd1);
         chk("c_addr", {31'd0, c_out_addr}, k);
         chk("c_data", {30'd0, c_out_data}, (k == 0) ? 32'd1 : 32'd2);
         chk("c_unst", {30'd0, c_out_unstable}, 32'd0);
         @(posedge clk); #1;
      end
      chk("c_done", {31'd0, c_done}, 32'd1);
      chk("c_valid_off", {31'd0, c_out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
